// File: rtl/ahb_regif_bridge.sv
// ahb_regif_bridge: AHB slave bridging the system bus to the LCD controller register file
// Params : ADDR_W (word-index width), REG_DEPTH (mapped words), RD_WAIT (extra read wait states, 0..7)
// Bus    : HCLOCK, HRESETn (async, active-low), HSEL, HREADYIN, HADDRESS, HWRITE, HTRANS, HSIZE,
//          HBURST, HWDATA -> HRDATA, HREADY, HRESP
// Regfile: reg_addr, reg_wr, reg_rd, reg_be, reg_wdata -> ; <- reg_rdata ; err_cnt saturating error count
// Build  : define AHB_REGIF_SUBWORD_EN to allow byte/halfword transfers with decoded byte enables
module ahb_regif_bridge #(
  parameter int ADDR_W = 8,
  parameter int REG_DEPTH = 128,
  parameter int RD_WAIT = 1
) (
  input  logic              HCLOCK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADYIN,
  input  logic [31:0]       HADDRESS,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADY,
  output logic [1:0]        HRESP,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic [3:0]        reg_be,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  output logic [7:0]        err_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_WAIT, S_RD_LAST, S_ERR1, S_ERR2} state_t;
  localparam logic [31:0] DEPTH = REG_DEPTH;
  localparam logic [2:0] WAITS = 3'(RD_WAIT);
  state_t state;
  logic [2:0] wait_cnt;
  logic burst_act;
  logic open_st, accept, bad, size_bad, misalign, wrap, unmapped, seq_orphan;
  logic [ADDR_W-1:0] idx;
  logic [3:0] be;
  logic unused_addr;
  assign unused_addr = ^HADDRESS[31:ADDR_W+2];
  assign idx = HADDRESS[ADDR_W+1:2];
  assign open_st = state inside {S_IDLE, S_WR, S_RD_LAST};
  assign accept = open_st & HSEL & HREADYIN & HTRANS[1];
  // burst_act remembers a legal transfer so a SEQ after BUSY stays legal
  assign seq_orphan = HTRANS == 2'b11 && !burst_act;
  assign wrap = HBURST[2:1] != 2'b00 && !HBURST[0];
  assign unmapped = 32'(idx) >= DEPTH;
`ifdef AHB_REGIF_SUBWORD_EN
  assign size_bad = HSIZE > 3'd2;
  assign misalign = (HSIZE == 3'd1 && HADDRESS[0]) || (HSIZE == 3'd2 && HADDRESS[1:0] != 2'b00);
  assign be = HSIZE == 3'd0 ? 4'b0001 << HADDRESS[1:0] : HSIZE == 3'd1 ? (HADDRESS[1] ? 4'b1100 : 4'b0011) : 4'hF;
`else
  assign size_bad = HSIZE != 3'd2;
  assign misalign = HADDRESS[1:0] != 2'b00;
  assign be = 4'hF;
`endif
  assign bad = seq_orphan | size_bad | misalign | wrap | unmapped;
  assign reg_wdata = HWDATA;
  always_ff @(posedge HCLOCK or negedge HRESETn)
    if (!HRESETn) begin
      state <= S_IDLE;
      wait_cnt <= 3'd0;
      burst_act <= 1'b0;
      HREADY <= 1'b1;
      HRESP <= 2'b00;
      HRDATA <= 32'h0;
      reg_addr <= '0;
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      reg_be <= 4'h0;
      err_cnt <= 8'h0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      // IDLE or deselect ends the burst; BUSY keeps it alive
      if (open_st && HREADYIN && (!HSEL || HTRANS == 2'b00)) burst_act <= 1'b0;
      if (accept) begin
        burst_act <= !bad;
        if (bad) begin
          state <= S_ERR1;
          HREADY <= 1'b0;
          HRESP <= 2'b01;
          err_cnt <= err_cnt + 8'(err_cnt != 8'hFF);
        end else begin
          state <= HWRITE ? S_WR : S_RD_WAIT;
          HREADY <= HWRITE;
          HRESP <= 2'b00;
          reg_addr <= idx;
          reg_be <= be;
          reg_wr <= HWRITE;
          reg_rd <= !HWRITE;
          wait_cnt <= WAITS;
        end
      end else begin
        case (state)
          S_RD_WAIT:
            if (wait_cnt == 3'd0) begin
              state <= S_RD_LAST;
              HREADY <= 1'b1;
              HRDATA <= reg_rdata;
            end else wait_cnt <= wait_cnt - 3'd1;
          S_ERR1: begin
            state <= S_ERR2;
            HREADY <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            HREADY <= 1'b1;
            HRESP <= 2'b00;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_ahb_regif_bridge.sv
// tb_ahb_regif_bridge: randomized self-checking bench with a transaction-level response model
module tb_ahb_regif_bridge;
  localparam int RDW = 1;
  typedef struct packed {
    logic rdy;
    logic [1:0] resp;
    logic wr;
    logic rd;
    logic [7:0] addr;
    logic [3:0] be;
    logic ld;
    logic [31:0] ldv;
    logic acc;
  } rec_t;
  localparam rec_t IDLE_REC = '{rdy:1'b1, resp:2'b00, wr:1'b0, rd:1'b0, addr:8'h0, be:4'h0, ld:1'b0, ldv:32'h0, acc:1'b1};
  logic HCLOCK = 0, HRESETn = 0, HSEL = 0, HWRITE = 0, stall = 0;
  logic [1:0] HTRANS = 0;
  logic [2:0] HSIZE = 3'd2, HBURST = 0;
  logic [31:0] HADDRESS = 0, HWDATA = 0, reg_rdata = 0;
  logic HREADYIN, HREADY, reg_wr, reg_rd;
  logic [1:0] HRESP;
  logic [31:0] HRDATA, reg_wdata;
  logic [7:0] reg_addr, err_cnt;
  logic [3:0] reg_be;
  int errors = 0, checks = 0;
  logic [31:0] mem [256];
  rec_t q[$];
  rec_t cur;
  logic in_burst = 0, opp, bad, rs;
  logic [31:0] hr_exp = 0, a;
  logic [7:0] ra;
  logic [3:0] be;
  logic [2:0] s;
  int err_m = 0, idx, sz;
  int tt[6] = '{2, 3, 1, 3, 3, 0};
  int ta[6] = '{32'h20, 32'h24, 32'h28, 32'h28, 32'h2C, 0};
  int ew[5] = '{1, 1, 0, 1, 1};
  int ea[5] = '{8, 9, 0, 10, 11};

  assign HREADYIN = HREADY & ~stall;
  always #5 HCLOCK = ~HCLOCK;

  ahb_regif_bridge #(.ADDR_W(8), .REG_DEPTH(128), .RD_WAIT(RDW)) dut (
    .HCLOCK(HCLOCK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADYIN(HREADYIN), .HADDRESS(HADDRESS),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_be(reg_be), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .err_cnt(err_cnt)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge HCLOCK);
    #2;
  endtask

  task automatic bus(logic sel, logic [1:0] tr, logic [31:0] ad, logic w, logic [2:0] z, logic [2:0] bu, logic [31:0] wd);
    HSEL = sel; HTRANS = tr; HADDRESS = ad; HWRITE = w; HSIZE = z; HBURST = bu; HWDATA = wd;
  endtask

  function automatic rec_t mk(logic rdy, logic [1:0] resp, logic wr, logic rd, logic [7:0] ad, logic [3:0] b, logic ld, logic [31:0] ldv, logic acc);
    mk = {rdy, resp, wr, rd, ad, b, ld, ldv, acc};
  endfunction

  // register file: data appears the cycle after a read strobe, noise otherwise
  initial forever begin
    @(posedge HCLOCK);
    rs = reg_rd;
    ra = reg_addr;
    #1;
    reg_rdata = rs ? mem[ra] : $urandom();
  end

  // model: each accepted transfer expands into the list of data-phase cycles it must produce
  initial forever begin
    @(posedge HCLOCK or negedge HRESETn);
    if (!HRESETn) begin
      q.delete();
      in_burst = 0;
      hr_exp = 0;
      err_m = 0;
    end else begin
      opp = q.size() == 0 || q[0].acc;
      if (q.size() != 0) void'(q.pop_front());
      if (opp && !stall) begin
        if (HSEL && HTRANS[1]) begin
          idx = int'(HADDRESS[9:2]);
          sz = int'(HSIZE);
`ifdef AHB_REGIF_SUBWORD_EN
          bad = sz > 2;
`else
          bad = sz != 2;
`endif
          bad = bad || (HTRANS == 2'b11 && !in_burst) || (HADDRESS % (1 << sz)) != 0 ||
                HBURST inside {3'd2, 3'd4, 3'd6} || idx >= 128;
          in_burst = !bad;
          if (bad) begin
            if (err_m < 255) err_m++;
            q.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 8'h0, 4'h0, 1'b0, 32'h0, 1'b0));
            q.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h0, 4'h0, 1'b0, 32'h0, 1'b0));
          end else begin
            be = 4'(((1 << (1 << sz)) - 1) << HADDRESS[1:0]);
            if (HWRITE) q.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, 8'(idx), be, 1'b0, 32'h0, 1'b1));
            else begin
              for (int i = 0; i <= RDW; i++) q.push_back(mk(1'b0, 2'b00, 1'b0, i == 0, 8'(idx), be, 1'b0, 32'h0, 1'b0));
              q.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 8'(idx), be, 1'b1, mem[idx], 1'b1));
            end
          end
        end else if (!HSEL || HTRANS == 2'b00) in_burst = 0;
      end
      if (q.size() != 0 && q[0].ld) hr_exp = q[0].ldv;
    end
  end

  initial forever begin
    @(negedge HCLOCK);
    cur = (q.size() != 0) ? q[0] : IDLE_REC;
    chk("hready", 32'(HREADY), 32'(cur.rdy));
    chk("hresp", 32'(HRESP), 32'(cur.resp));
    chk("reg_wr", 32'(reg_wr), 32'(cur.wr));
    chk("reg_rd", 32'(reg_rd), 32'(cur.rd));
    chk("reg_wdata", reg_wdata, HWDATA);
    chk("hrdata", HRDATA, hr_exp);
    chk("err_cnt", 32'(err_cnt), err_m);
    if (cur.wr || cur.rd) begin
      chk("reg_addr", 32'(reg_addr), 32'(cur.addr));
      chk("reg_be", 32'(reg_be), 32'(cur.be));
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[2] = 32'h1234_5678;
    repeat (3) @(posedge HCLOCK);
    @(negedge HCLOCK);
    chk("rst_hready", 32'(HREADY), 1);
    chk("rst_hresp", 32'(HRESP), 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wr", 32'(reg_wr), 0);
    chk("rst_rd", 32'(reg_rd), 0);
    chk("rst_be", 32'(reg_be), 0);
    chk("rst_errcnt", 32'(err_cnt), 0);
    step;
    HRESETn = 1;
    step; bus(1, 2'b10, 32'h10, 1, 3'd2, 3'd0, 0);
    step; bus(0, 2'b00, 0, 0, 3'd2, 3'd0, 32'hA5A5_0001);
    @(negedge HCLOCK);
    chk("t1_wr", 32'(reg_wr), 1);
    chk("t1_addr", 32'(reg_addr), 4);
    chk("t1_be", 32'(reg_be), 32'hF);
    chk("t1_wdata", reg_wdata, 32'hA5A5_0001);
    chk("t1_rdy", 32'(HREADY), 1);
    step;
    @(negedge HCLOCK);
    chk("t1_rdy2", 32'(HREADY), 1);
    chk("t1_wr2", 32'(reg_wr), 0);
    step; bus(1, 2'b10, 32'h08, 0, 3'd2, 3'd0, 0);
    step; bus(0, 2'b00, 0, 0, 3'd2, 3'd0, 0);
    @(negedge HCLOCK);
    chk("t2_rdy0", 32'(HREADY), 0);
    chk("t2_rd", 32'(reg_rd), 1);
    step;
    @(negedge HCLOCK);
    chk("t2_rdy1", 32'(HREADY), 0);
    chk("t2_rd1", 32'(reg_rd), 0);
    step;
    @(negedge HCLOCK);
    chk("t2_rdy2", 32'(HREADY), 1);
    chk("t2_data", HRDATA, 32'h1234_5678);
    chk("t2_resp", 32'(HRESP), 0);
    for (int k = 0; k < 6; k++) begin
      step; bus(k < 5, 2'(tt[k]), ta[k], 1, 3'd2, 3'b011, $urandom());
      if (k > 0) begin
        @(negedge HCLOCK);
        chk("t3_wr", 32'(reg_wr), ew[k-1]);
        chk("t3_rdy", 32'(HREADY), 1);
        if (ew[k-1] != 0) chk("t3_addr", 32'(reg_addr), ea[k-1]);
      end
    end
    step; bus(1, 2'b10, 32'h200, 0, 3'd2, 3'd0, 0);
    step; bus(0, 2'b00, 0, 0, 3'd2, 3'd0, 0);
    @(negedge HCLOCK);
    chk("t4_rdy", 32'(HREADY), 0);
    chk("t4_resp", 32'(HRESP), 1);
    chk("t4_rd", 32'(reg_rd), 0);
    chk("t4_cnt", 32'(err_cnt), 1);
    step; bus(1, 2'b11, 32'h08, 0, 3'd2, 3'd1, 0);
    @(negedge HCLOCK);
    chk("t4_rdy2", 32'(HREADY), 1);
    chk("t4_resp2", 32'(HRESP), 1);
    step;
    @(negedge HCLOCK);
    chk("t4_idle_resp", 32'(HRESP), 0);
    chk("t4_idle_cnt", 32'(err_cnt), 1);
    step; bus(0, 2'b00, 0, 0, 3'd2, 3'd0, 0);
    @(negedge HCLOCK);
    chk("t4_cnt2", 32'(err_cnt), 2);
    chk("t4_resp3", 32'(HRESP), 1);
    chk("t4_rd3", 32'(reg_rd), 0);
    step; step;
    step; bus(1, 2'b10, 32'h13, 1, 3'd0, 3'd0, 0);
    step; bus(0, 2'b00, 0, 0, 3'd2, 3'd0, 32'hCAFE_0013);
    @(negedge HCLOCK);
`ifdef AHB_REGIF_SUBWORD_EN
    chk("t5_wr", 32'(reg_wr), 1);
    chk("t5_be", 32'(reg_be), 32'b1000);
    chk("t5_resp", 32'(HRESP), 0);
`else
    chk("t5_resp", 32'(HRESP), 1);
    chk("t5_wr", 32'(reg_wr), 0);
    chk("t5_rdy", 32'(HREADY), 0);
`endif
    step; step;
    step; bus(1, 2'b10, 32'h08, 0, 3'd2, 3'd0, 0);
    step; bus(0, 2'b00, 0, 0, 3'd2, 3'd0, 0);
    @(negedge HCLOCK);
    chk("t6_rdy", 32'(HREADY), 0);
    #1 HRESETn = 0;
    #1;
    chk("t6_rst_rdy", 32'(HREADY), 1);
    chk("t6_rst_resp", 32'(HRESP), 0);
    chk("t6_rst_data", HRDATA, 0);
    chk("t6_rst_rd", 32'(reg_rd), 0);
    step;
    HRESETn = 1;
    step; bus(1, 2'b10, 32'h08, 0, 3'd2, 3'd0, 0);
    step; bus(0, 2'b00, 0, 0, 3'd2, 3'd0, 0);
    @(negedge HCLOCK);
    chk("t6_rd", 32'(reg_rd), 1);
    step; step;
    @(negedge HCLOCK);
    chk("t6_data", HRDATA, 32'h1234_5678);
    chk("t6_rdy2", 32'(HREADY), 1);
    for (int n = 0; n < 4000; n++) begin
      step;
      stall = $urandom_range(0, 7) == 0;
      a = $urandom_range(0, 32'h23F);
      s = ($urandom_range(0, 9) < 6) ? 3'd2 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << s) - 32'd1);
      bus($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)), s,
          3'($urandom_range(0, 7)), $urandom());
    end
    step;
    stall = 0;
    bus(1, 2'b10, 32'h200, 0, 3'd2, 3'd0, 0);
    repeat (800) step;
    @(negedge HCLOCK);
    chk("sat_cnt", 32'(err_cnt), 255);
    step; bus(0, 2'b00, 0, 0, 3'd2, 3'd0, 0);
    repeat (3) step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_regif_bridge.md
# ahb_regif_bridge

Parametrised AHB slave bridging the system bus to the LCD controller register file. Decodes one AHB transfer per address phase, pipelines writes with zero wait states, inserts a programmable number of read wait states, and returns a two-cycle ERROR response for illegal or unmapped accesses. Sits between the AHB interconnect and the segment/LCD register bank. It supersedes the fixed-word, single-latency slave state machine.

## Interface
- ADDR_W, 8: register word-address width; `reg_addr` is HADDRESS[ADDR_W+1:2].
- REG_DEPTH, 128: number of mapped words; word index >= REG_DEPTH is unmapped.
- RD_WAIT, 1: extra read wait states, 0..7.
- Reset is HRESETn: asynchronous, active-low. Clock is HCLOCK.
- HCLOCK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HREADYIN  in  1  bus ready; address phase is sampled only when high.
- HADDRESS  in  32  byte address.
- HWRITE  in  1  1 = write.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type.
- HWDATA  in  32  write data.
- HRDATA  out  32  read data, registered.
- HREADY  out  1  slave ready.
- HRESP  out  2  OKAY=00, ERROR=01.
- reg_addr  out  ADDR_W  register word index, registered.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_be  out  4  byte enables.
- reg_wdata  out  32  = HWDATA, combinational.
- reg_rdata  in  32  register data, valid the cycle after `reg_rd`.
- err_cnt  out  8  saturating count of ERROR responses.

## Operation
- A transfer is accepted when HSEL & HREADYIN & HTRANS[1] at a rising edge and the state is IDLE, WR, or RD_LAST.
- An accepted transfer is an error if any of the following holds:
  - SEQ is presented with no transfer in progress.
  - HSIZE is illegal (see Configuration).
  - The address is misaligned to HSIZE.
  - HBURST is a WRAP type (010, 100, 110).
  - The word index is >= REG_DEPTH.
- SINGLE and all INCR bursts are legal.
- States:
  - IDLE: HREADY=1, HRESP=OKAY.
  - WR: one-cycle data phase.
    - `reg_wr`=1, `reg_addr`/`reg_be` hold the latched values, HREADY=1.
    - A pipelined next transfer may be accepted in this cycle.
  - RD_WAIT: HREADY=0. `reg_rd`=1 in the first cycle only.
    - A 3-bit counter holds the state for RD_WAIT+1 cycles total.
    - `reg_rdata` is captured into HRDATA on the last cycle.
  - RD_LAST: HREADY=1, HRDATA valid, next transfer may be accepted.
  - ERR1: HREADY=0, HRESP=ERROR.
  - ERR2: HREADY=1, HRESP=ERROR. Transfers presented in ERR2 are ignored. Return to IDLE.
- BUSY or IDLE sampled in WR/RD_LAST: no access; go to IDLE. BUSY holds burst context, so a following SEQ is legal.
- `err_cnt` increments on ERR1 entry and saturates at 255.

## Timing
- Reset values:
  - HREADY=1, HRESP=00, HRDATA=0.
  - `reg_addr`=0, `reg_wr`=0, `reg_rd`=0, `reg_be`=0, `err_cnt`=0.
  - State is IDLE.
- Write: accept at edge N; `reg_wr` high in cycle N→N+1 with HWDATA; zero wait states.
- Read: accept at edge N; `reg_rd` high in cycle N→N+1; HREADY low for RD_WAIT+1 cycles; HRDATA valid with HREADY=1 in the following cycle.
- Back-to-back writes: one per cycle. Read followed by write: the write is accepted in RD_LAST.
- Error: exactly two cycles (ERR1, ERR2); no `reg_wr`/`reg_rd` is issued.
- HRESETn asserted mid-transfer: immediate return to reset values; any strobe in flight is dropped.

## Configuration
- AHB_REGIF_SUBWORD_EN, defined:
  - HSIZE 000 (byte) and 001 (halfword) are legal.
  - `reg_be` is decoded from HADDRESS[1:0] and HSIZE.
  - HRDATA is the full word.
- AHB_REGIF_SUBWORD_EN, undefined:
  - Any HSIZE other than 010 is an error.
  - `reg_be` is always 4'hF on access.

## Test plan
- Reset, then NONSEQ write to 0x10 with data 0xA5A5_0001 -> `reg_wr` pulse, `reg_addr`=4, `reg_be`=F, HREADY never low.
- RD_WAIT=1, read of 0x08 with `reg_rdata`=0x1234_5678 -> HREADY low 2 cycles, then HRDATA=0x1234_5678 with OKAY.
- INCR4 writes to 0x20..0x2C with one BUSY inserted -> 4 `reg_wr` pulses at addresses 8..11, none during BUSY.
- Read of 0x200 (index 128) -> ERR1 then ERR2, no strobe, `err_cnt`=1; a second SEQ from IDLE -> `err_cnt`=2.
- Byte write to 0x13: with the macro -> `reg_be`=4'b1000; without the macro -> ERROR.
- HRESETn asserted during RD_WAIT -> HREADY=1, HRESP=OKAY, HRDATA=0 immediately; next read completes normally.
